vga_frame_arbiter: RTL

Frame-synchronous update arbiter between the elevator control core and the VGA display path. Two requesters, the simulation core (destination/sim_state) and the call-button panel (pending-call mask), request display updates at any time. The block grants at most one commit per requester per vertical blanking interval, round-robin, and drives shadow registers that feed the pixel generator. Displayed data therefore never changes mid-frame.

---
 rtl/vga_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 51 +++++
 rtl/vga_frame_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA display-update path.
package vga_ctrl_pkg;

  // Arbiter state: ACTIVE outside blanking, ARB while granting, HOLD once both are served.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    ARB    = 2'd1,
    HOLD   = 2'd2
  } arb_state_e;

  // Requester indices into eligible/grant/served vectors.
  localparam int SIM   = 0;
  localparam int PANEL = 1;

  // Default field widths, shared with the pixel generator.
  localparam int DEST_W_DEF = 8;
  localparam int CALL_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer only moves on a contested grant,
// so a lone requester never steals the other's turn.
module rr_arbiter2
  import vga_ctrl_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       rr_ptr
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Pick the single eligible requester, or the pointed-to one when both compete.
  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    case (eligible)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (rr_ptr_q == 1'(PANEL)) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
        if (advance) begin
          rr_ptr_d = ~rr_ptr_q;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  // Round-robin pointer register; SIM has first priority after reset.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'(SIM);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/vga_frame_arbiter.sv
// Frame-synchronous update arbiter: commits simulation and panel data into
// display shadow registers only during vertical blanking, one commit per
// requester per blank, so the visible frame never changes mid-scan.
module vga_frame_arbiter
  import vga_ctrl_pkg::*;
#(
  parameter int DEST_W = DEST_W_DEF,
  parameter int CALL_W = CALL_W_DEF
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              sim_req,
  input  logic [DEST_W-1:0] sim_destination,
  input  logic [1:0]        sim_state,
  output logic              sim_ack,
  input  logic              panel_req,
  input  logic [CALL_W-1:0] panel_calls,
  output logic              panel_ack,
  output logic [DEST_W-1:0] disp_destination,
  output logic [1:0]        disp_sim_state,
  output logic [CALL_W-1:0] disp_calls,
  output logic              frame_start,
  output logic [7:0]        frame_count,
  output logic              update_pending
);

  arb_state_e        state_q, state_d;
  logic [1:0]        served_q, served_d;
  logic              vblank_q;
  logic              sim_ack_q, sim_ack_d;
  logic              panel_ack_q, panel_ack_d;
  logic [DEST_W-1:0] disp_destination_q, disp_destination_d;
  logic [1:0]        disp_sim_state_q, disp_sim_state_d;
  logic [CALL_W-1:0] disp_calls_q, disp_calls_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic              rise_s;
  logic              fall_s;
  logic [1:0]        eligible_s;
  logic [1:0]        grant_s;
  logic              rr_ptr_unused;

  assign rise_s = vblank & ~vblank_q;
  assign fall_s = ~vblank & vblank_q;

  // Only requesters not yet served in this blank compete, and only while arbitrating.
  assign eligible_s = (state_q == ARB) ? ({panel_req, sim_req} & ~served_q) : 2'b00;

  // Pointer is kept inside the arbiter; exposed only for debug visibility.
  rr_arbiter2 u_rr (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .eligible  (eligible_s),
    .advance   (state_q == ARB),
    .grant     (grant_s),
    .rr_ptr    (rr_ptr_unused)
  );

  // Next-state, commit and frame bookkeeping.
  always_comb begin
    state_d            = state_q;
    served_d           = served_q | grant_s;
    sim_ack_d          = grant_s[SIM];
    panel_ack_d        = grant_s[PANEL];
    disp_destination_d = disp_destination_q;
    disp_sim_state_d   = disp_sim_state_q;
    disp_calls_d       = disp_calls_q;
    frame_start_d      = fall_s;
    frame_count_d      = frame_count_q;

    if (grant_s[SIM]) begin
      disp_destination_d = sim_destination;
      disp_sim_state_d   = sim_state;
    end else begin
      disp_destination_d = disp_destination_q;
      disp_sim_state_d   = disp_sim_state_q;
    end

    if (grant_s[PANEL]) begin
      disp_calls_d = panel_calls;
    end else begin
      disp_calls_d = disp_calls_q;
    end

    if (fall_s) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end

    case (state_q)
      ACTIVE: begin
        if (rise_s) begin
          state_d  = ARB;
          served_d = 2'b00;
        end else begin
          state_d = ACTIVE;
        end
      end
      ARB: begin
        if (fall_s) begin
          state_d = ACTIVE;
        end else if (served_q == 2'b11) begin
          state_d = HOLD;
        end else begin
          state_d = ARB;
        end
      end
      HOLD: begin
        if (fall_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // State and shadow registers. vblank_q resets high so a blank already in
  // progress at reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q            <= ACTIVE;
      served_q           <= 2'b00;
      vblank_q           <= 1'b1;
      sim_ack_q          <= 1'b0;
      panel_ack_q        <= 1'b0;
      disp_destination_q <= '0;
      disp_sim_state_q   <= 2'b00;
      disp_calls_q       <= '0;
      frame_start_q      <= 1'b0;
      frame_count_q      <= 8'd0;
    end else begin
      state_q            <= state_d;
      served_q           <= served_d;
      vblank_q           <= vblank;
      sim_ack_q          <= sim_ack_d;
      panel_ack_q        <= panel_ack_d;
      disp_destination_q <= disp_destination_d;
      disp_sim_state_q   <= disp_sim_state_d;
      disp_calls_q       <= disp_calls_d;
      frame_start_q      <= frame_start_d;
      frame_count_q      <= frame_count_d;
    end
  end

  assign sim_ack          = sim_ack_q;
  assign panel_ack        = panel_ack_q;
  assign disp_destination = disp_destination_q;
  assign disp_sim_state   = disp_sim_state_q;
  assign disp_calls       = disp_calls_q;
  assign frame_start      = frame_start_q;
  assign frame_count      = frame_count_q;
  assign update_pending   = (sim_req & ~served_q[SIM]) | (panel_req & ~served_q[PANEL]);

endmodule
